// File: rtl/pipe_pkg.sv
//==============================================================================
// Module : pipe_pkg
// Brief  : Shared defaults, stage-occupancy state type and control bit indices
//          for the inter-stage pipeline register.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package pipe_pkg;

    localparam int unsigned C_DATA_W = 64;
    localparam int unsigned C_CTRL_W = 12;
    localparam int unsigned C_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // Bit positions inside the control sideband
    localparam int unsigned C_CTRL_REG_WRITE   = 0;
    localparam int unsigned C_CTRL_MEM_WRITE   = 1;
    localparam int unsigned C_CTRL_MEM_READ    = 2;
    localparam int unsigned C_CTRL_REG_SRC_LSB = 3;

endpackage

`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
//==============================================================================
// Module : pipe_sat_cnt
// Brief  : Saturating up-counter; holds at all-ones, cleared by reset.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module pipe_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
//==============================================================================
// Module : pipe_stage_buf
// Brief  : Inter-stage pipeline register with valid/ready handshake, flush,
//          bubble gating of control and a saturating stall counter.
//          Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a
//          registered ready_o; otherwise a single entry with pass-through ready.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = C_DATA_W,
    parameter int unsigned CTRL_W = C_CTRL_W,
    parameter int unsigned CNT_W  = C_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_e       state_q,     state_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign valid_o    = (state_q != ST_EMPTY);
    assign w_in_xfer  = valid_i && ready_o;
    assign w_out_xfer = valid_o && ready_i;
    assign data_o     = head_data_q;
    // A bubble must never present a write enable downstream
    assign ctrl_o     = head_ctrl_q & {CTRL_W{valid_o}};

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              ready_q,     ready_d;

    assign ready_o = ready_q;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    state_d     = ST_ONE;
                    head_data_d = data_i;
                    head_ctrl_d = ctrl_i;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    head_data_d = data_i;
                    head_ctrl_d = ctrl_i;
                end else if (w_in_xfer) begin
                    state_d     = ST_TWO;
                    skid_data_d = data_i;
                    skid_ctrl_d = ctrl_i;
                end else if (w_out_xfer) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_xfer) begin
                    state_d     = ST_ONE;
                    head_data_d = skid_data_q;
                    head_ctrl_d = skid_ctrl_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
        // Ready is precomputed from the next state so it comes straight off a flop
        ready_d = (state_d != ST_TWO);
    end
`else
    assign ready_o = !valid_o || ready_i;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    state_d     = ST_ONE;
                    head_data_d = data_i;
                    head_ctrl_d = ctrl_i;
                end
            end
            ST_ONE: begin
                if (w_in_xfer) begin
                    head_data_d = data_i;
                    head_ctrl_d = ctrl_i;
                end else if (w_out_xfer) begin
                    state_d     = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_ctrl_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            ready_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            ready_q     <= ready_d;
`endif
        end
    end

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (valid_o && !ready_i),
        .cnt_o (stall_cnt_o)
    );

endmodule

`default_nettype wire
